imem_responder: RTL
===================

# imem_responder

Instruction-memory responder for the pipeline's fetch stage. Accepts word fetch requests from the fetch/decode stage. Returns `inst_mem_read_data` with an `inst_mem_is_valid` strobe after a programmable number of wait states. Holds a word-addressed instruction store that a boot/debug load port writes.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words in the store; must be a power of two, 4..65536.
- `WAIT_STATES`, 0: extra cycles between request acceptance and response; 0..15.
- `BASE`, 32'h0000_0000: byte address of word 0.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `reset`  in  1: asynchronous, active-low reset.
- `inst_mem_req`  in  1: fetch request strobe; qualified by `!inst_mem_busy`.
- `inst_mem_address`  in  32: byte address of the requested word.
- `inst_mem_busy`  out  1: high while a request is outstanding and no new request can be accepted.
- `inst_mem_is_valid`  out  1: one-cycle pulse; `inst_mem_read_data` is valid in that cycle.
- `inst_mem_read_data`  out  32: fetched instruction; holds its last value when not valid.
- `inst_mem_error`  out  1: see Configuration; sticky until reset.
- `load_we`  in  1: load-port write enable.
- `load_addr`  in  log2(DEPTH): word index to write.
- `load_data`  in  32: word to write.

## Operation
- Word index = (`inst_mem_address` − `BASE`) >> 2, truncated to log2(DEPTH) bits.
- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE:** `busy`=0. If `req` is high, the block latches the index and its error condition.
  - With `WAIT_STATES`=0 it goes to RESP.
  - Otherwise it loads the counter with `WAIT_STATES` and goes to WAIT.
- **WAIT:** `busy`=1. `req` is ignored and dropped. The counter decrements each cycle. When the counter is 1, the store is read into the data register and the FSM goes to RESP.
  - With `WAIT_STATES`=0 the read happens on the accept edge.
- **RESP:** `is_valid`=1 and `busy`=0. If `req` is high in RESP, it is accepted exactly as in IDLE, which gives back-to-back operation. Otherwise the FSM goes to IDLE.
- **Load port:** if `load_we` is high, `mem[load_addr]` <= `load_data` on the edge. This happens in any state.
  - If a load and a read of the same word occur on the same edge, the read returns the old word.
- **Reset:** `is_valid`=0, `busy`=0, `read_data`=32'h0, `error`=0, FSM in IDLE, counter 0.
  - Store contents are not cleared.
  - A request outstanding at reset is discarded and produces no response.

## Timing
- Latency: the response is valid `WAIT_STATES`+1 cycles after the accept edge. With `WAIT_STATES`=0, a request at cycle n is valid at cycle n+1.
- Throughput: with `WAIT_STATES`=0 the block sustains one response per cycle. Otherwise it sustains one per `WAIT_STATES`+1 cycles, using the RESP-cycle accept.
- `busy` and `is_valid` are registered FSM decodes with no combinational path from `req`.
- `read_data` changes only on the edge entering RESP.

## Configuration
- `IMEM_BOUNDS_CHECK_EN` defined: a request is erroneous if `address[1:0]`≠0, or if `address` < `BASE`, or if `address` ≥ `BASE`+4·`DEPTH`.
  - An erroneous request still completes with normal timing.
  - Its response data is 32'h0000_0013 (NOP).
  - `inst_mem_error` is set on that response's valid cycle and stays set until reset.
- `IMEM_BOUNDS_CHECK_EN` undefined: the address wraps modulo `DEPTH` words, `address[1:0]` is ignored, and `inst_mem_error` is tied to 0.

## Test plan
- Load `mem[0..3]`={32'h03010413, 32'h000017b7, 32'h02178793, 32'hfef41123} with `WAIT_STATES`=0, then issue `req` for 0, 4, 8 and 12 on consecutive cycles. Required: `is_valid` high on 4 consecutive cycles, each one cycle after its request, returning the 4 words in order, with `busy` never high.
- With `WAIT_STATES`=3, request address 4, then hold `req` high for the next 3 cycles with address 8. Required: `busy`=1 for 3 cycles, then a valid pulse with 32'h000017b7 4 cycles after the accept. The requests made during busy are dropped; the address-8 request asserted in the RESP cycle is accepted.
- Issue a load of `mem[2]`=32'hDEADBEEF on the same edge that reads word 2. Required: that response returns the old value 32'h02178793. The next read of word 2 returns 32'hDEADBEEF.
- Assert `reset` low during WAIT with `WAIT_STATES`=5. Required: all outputs return to their reset values immediately and no valid pulse follows. Store contents survive the reset.
- With `IMEM_BOUNDS_CHECK_EN` defined and `DEPTH`=1024, request 32'h0000_1000 and then 32'h0000_0002. Required: both responses return 32'h0000_0013, `error` is set on the first valid cycle and stays set.
- With `IMEM_BOUNDS_CHECK_EN` undefined, the same request for 32'h0000_1000 returns `mem[0]`.

Source files
------------

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder for the fetch stage
//
// Purpose: word-addressed instruction store with a fetch request/response
// port and a boot/debug load port. A fetch accepted in IDLE or RESP returns
// its word WAIT_STATES+1 cycles later with a one-cycle valid strobe.
//
// Optional feature: define IMEM_BOUNDS_CHECK_EN to flag misaligned or
// out-of-range fetches (response data becomes NOP, sticky error raised).
// Without it the address wraps modulo DEPTH words and error is tied low.
//
// Ports:
//   clk                 clock, all logic on posedge
//   reset               asynchronous active-low reset
//   inst_mem_req        fetch request strobe, taken when not busy
//   inst_mem_address    byte address of the requested word
//   inst_mem_busy       a fetch is waiting; new requests are dropped
//   inst_mem_is_valid   one-cycle pulse, read_data valid
//   inst_mem_read_data  fetched word, held between responses
//   inst_mem_error      sticky bounds error (bounds-check build only)
//   load_we             load-port write enable
//   load_addr           load-port word index
//   load_data           load-port write data

module imem_responder #(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE        = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inst_mem_req,
  input  logic [31:0]              inst_mem_address,
  output logic                     inst_mem_busy,
  output logic                     inst_mem_is_valid,
  output logic [31:0]              inst_mem_read_data,
  output logic                     inst_mem_error,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
);

  localparam int         AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state;
  state_t        next_state;
  logic [31:0]   mem [DEPTH];
  logic [3:0]    cnt;
  logic [AW-1:0] idx;
  logic [31:0]   addr_off;
  logic [AW-1:0] req_idx;
  logic          accept;
  logic          wait_done;
  logic          rd_en;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;
  logic          unused_addr_bits;

  assign addr_off         = inst_mem_address - BASE;
  assign req_idx          = addr_off[AW+1:2];
  assign unused_addr_bits = &{1'b0, addr_off[31:AW+2], addr_off[1:0]};

  // Requests are taken in IDLE and RESP; RESP acceptance gives back-to-back fetches.
  assign accept    = inst_mem_req && ((state == S_IDLE) || (state == S_RESP));
  assign wait_done = (state == S_WAIT) && (cnt == 4'd1);

  // With no wait states the store is read on the accept edge straight from the
  // request address; otherwise on the last WAIT edge from the latched index.
  assign rd_en  = wait_done || (accept && (WS == 4'd0));
  assign rd_idx = wait_done ? idx : req_idx;

`ifdef IMEM_BOUNDS_CHECK_EN
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [32:0] limit;
  logic        req_err;
  logic        idx_err;
  logic        rd_err;
  logic        err_q;

  assign limit   = {1'b0, BASE} + (33'(DEPTH) << 2);
  assign req_err = (inst_mem_address[1:0] != 2'b00) ||
                   (inst_mem_address < BASE) ||
                   ({1'b0, inst_mem_address} >= limit);
  assign rd_err  = wait_done ? idx_err : req_err;
  assign rd_word = rd_err ? NOP : mem[rd_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_err <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        idx_err <= req_err;
      end
      // Raised on the edge entering RESP so it is visible in the valid cycle.
      if (rd_en && rd_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign inst_mem_error = err_q;
`else
  assign rd_word        = mem[rd_idx];
  assign inst_mem_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state        = state;
    inst_mem_busy     = 1'b0;
    inst_mem_is_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (inst_mem_req) begin
          next_state = (WS == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        inst_mem_busy = 1'b1;
        if (cnt == 4'd1) begin
          next_state = S_RESP;
        end
      end
      S_RESP: begin
        inst_mem_is_valid = 1'b1;
        if (inst_mem_req) begin
          next_state = (WS == 4'd0) ? S_RESP : S_WAIT;
        end else begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt                <= 4'd0;
      idx                <= '0;
      inst_mem_read_data <= 32'h0;
    end else begin
      if (accept) begin
        cnt <= WS;
        idx <= req_idx;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (rd_en) begin
        inst_mem_read_data <= rd_word;
      end
    end
  end

  // Store is not reset; a same-edge load and read returns the old word.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule
